// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the picorv32
// instruction and data ports, with window check and one-cycle response routing.
module picorv32_mem_arbiter #(
  parameter int unsigned Depth    = 1 << 20,
  parameter logic [31:0] BaseAddr = 32'h8000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     instr_req_i,
  input  logic                     instr_we_i,
  input  logic [31:0]              instr_addr_i,
  input  logic [31:0]              instr_wdata_i,
  input  logic [3:0]               instr_strb_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [31:0]              instr_rdata_o,
  output logic                     instr_err_o,

  input  logic                     data_req_i,
  input  logic                     data_we_i,
  input  logic [31:0]              data_addr_i,
  input  logic [31:0]              data_wdata_i,
  input  logic [3:0]               data_strb_i,
  output logic                     data_gnt_o,
  output logic                     data_rvalid_o,
  output logic [31:0]              data_rdata_o,
  output logic                     data_err_o,

  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [$clog2(Depth)-1:0] mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  output logic [31:0]              mem_wmask_o,
  input  logic [31:0]              mem_rdata_i
);

  localparam int unsigned AW       = $clog2(Depth);
  // 34-bit window size so Depth*4 cannot overflow the comparison
  localparam logic [33:0] WinBytes = 34'(Depth) << 2;

  typedef enum logic {
    PORT_INSTR,
    PORT_DATA
  } port_e;

  port_e       last_winner;
  port_e       owner_q;
  logic        valid_q;
  logic        err_q;
  logic        we_q;

  logic        gnt_instr;
  logic        gnt_data;
  logic        gnt_any;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_strb;
  logic [31:0] off;
  logic        in_window;
  logic        resp_live;

  always_comb begin
    gnt_instr = !rst_i && instr_req_i && (!data_req_i || last_winner == PORT_DATA);
    gnt_data  = !rst_i && data_req_i && (!instr_req_i || last_winner == PORT_INSTR);
    gnt_any   = gnt_instr || gnt_data;

    if (gnt_data) begin
      sel_we    = data_we_i;
      sel_addr  = data_addr_i;
      sel_wdata = data_wdata_i;
      sel_strb  = data_strb_i;
    end else begin
      sel_we    = instr_we_i;
      sel_addr  = instr_addr_i;
      sel_wdata = instr_wdata_i;
      sel_strb  = instr_strb_i;
    end

    // Wrap-around subtraction: addresses below the base land far above the window
    off       = sel_addr - BaseAddr;
    in_window = {2'b00, off} < WinBytes;

    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (gnt_any && in_window) begin
      mem_req_o   = 1'b1;
      mem_we_o    = sel_we;
      mem_addr_o  = off[2 +: AW];
      mem_wdata_o = sel_wdata;
      for (int unsigned b = 0; b < 4; b++) begin
        mem_wmask_o[8*b +: 8] = {8{sel_strb[b]}};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_winner <= PORT_INSTR;
      owner_q     <= PORT_INSTR;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      valid_q <= gnt_any;
      if (gnt_any) begin
        last_winner <= gnt_data ? PORT_DATA : PORT_INSTR;
        owner_q     <= gnt_data ? PORT_DATA : PORT_INSTR;
        err_q       <= !in_window;
        we_q        <= sel_we;
      end
    end
  end

  // Response is masked during reset so a pending completion is dropped at once
  assign resp_live      = valid_q && !rst_i;

  assign instr_gnt_o    = gnt_instr;
  assign instr_rvalid_o = resp_live && owner_q == PORT_INSTR;
  assign instr_err_o    = instr_rvalid_o && err_q;
  assign instr_rdata_o  = (instr_rvalid_o && !err_q && !we_q) ? mem_rdata_i : '0;

  assign data_gnt_o     = gnt_data;
  assign data_rvalid_o  = resp_live && owner_q == PORT_DATA;
  assign data_err_o     = data_rvalid_o && err_q;
  assign data_rdata_o   = (data_rvalid_o && !err_q && !we_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: directed vector table plus randomized traffic
// checked against a transaction-level model with its own shadow memory.
module tb_picorv32_mem_arbiter;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, instr_we, data_req, data_we;
  logic [31:0] instr_addr, instr_wdata, data_addr, data_wdata;
  logic [3:0]  instr_strb, data_strb;
  logic        instr_gnt, instr_rvalid, instr_err;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] instr_rdata, data_rdata;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_wmask, mem_rdata;

  logic        preload;
  logic [31:0] sram [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  int checks   = 0;
  int failures = 0;

  // Model state
  int          lw;          // 0 = instr won last, 1 = data won last
  bit          pv;
  int          pown;
  bit          perr;
  logic [31:0] pdata;
  bit          last_gi, last_gd;

  always #5 clk = ~clk;

  picorv32_mem_arbiter #(.Depth(DEPTH), .BaseAddr(BASE)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_we_i(instr_we), .instr_addr_i(instr_addr),
    .instr_wdata_i(instr_wdata), .instr_strb_i(instr_strb), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_strb_i(data_strb), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    logic [31:0] w;
    w = (i == 5) ? 32'hDEAD_BEEF : ((i * 32'h9E37_79B9) ^ 32'h5A5A_5A5A);
    return w;
  endfunction

  // Single-port SRAM with one-cycle read latency
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
    end else if (mem_req) begin
      if (mem_we) sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: compare this cycle's outputs, then advance state
  task automatic model_step();
    bit          gi, gd, win, mreq, we;
    logic [31:0] a, wd, off, mask;
    logic [3:0]  st;
    int          idx;
    bit          rvi, rvd;
    gi   = !rst && instr_req && (!data_req || lw == 1);
    gd   = !rst && data_req && (!instr_req || lw == 0);
    a    = gd ? data_addr  : instr_addr;
    we   = gd ? data_we    : instr_we;
    wd   = gd ? data_wdata : instr_wdata;
    st   = gd ? data_strb  : instr_strb;
    off  = a - BASE;
    win  = {32'b0, off} < 64'(DEPTH) * 4;
    idx  = int'(off / 4);
    mreq = (gi || gd) && win;
    mask = '0;
    for (int b = 0; b < 4; b++) if (st[b]) mask |= 32'hFF << (8 * b);

    chk("instr_gnt", 32'(instr_gnt), 32'(gi));
    chk("data_gnt",  32'(data_gnt),  32'(gd));
    chk("mem_req",   32'(mem_req),   32'(mreq));
    chk("mem_we",    32'(mem_we),    mreq ? 32'(we) : 32'd0);
    chk("mem_addr",  32'(mem_addr),  mreq ? 32'(idx) : 32'd0);
    chk("mem_wdata", mem_wdata,      mreq ? wd : 32'd0);
    chk("mem_wmask", mem_wmask,      mreq ? mask : 32'd0);

    rvi = !rst && pv && pown == 0;
    rvd = !rst && pv && pown == 1;
    chk("instr_rvalid", 32'(instr_rvalid), 32'(rvi));
    chk("instr_err",    32'(instr_err),    32'(rvi && perr));
    chk("instr_rdata",  instr_rdata,       rvi ? pdata : 32'd0);
    chk("data_rvalid",  32'(data_rvalid),  32'(rvd));
    chk("data_err",     32'(data_err),     32'(rvd && perr));
    chk("data_rdata",   data_rdata,        rvd ? pdata : 32'd0);

    last_gi = gi;
    last_gd = gd;
    if (rst) begin
      lw = 0;
      pv = 0;
    end else if (gi || gd) begin
      lw    = gd ? 1 : 0;
      pv    = 1;
      pown  = gd ? 1 : 0;
      perr  = !win;
      pdata = (!win || we) ? 32'd0 : ref_mem[idx];
      if (win && we) ref_mem[idx] = (ref_mem[idx] & ~mask) | (wd & mask);
    end else begin
      pv = 0;
    end
  endtask

  typedef struct {
    logic        rst;
    logic        ireq, iwe;
    logic [31:0] iaddr, iwdata;
    logic [3:0]  istrb;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dstrb;
    logic        egi, egd, ereq, ewe;
    logic [9:0]  eaddr;
    logic [31:0] emask;
  } vec_t;

  function automatic vec_t mk(logic r, logic ir, logic iw, logic [31:0] ia, logic [31:0] iwd,
                              logic [3:0] is, logic dr, logic dw, logic [31:0] da,
                              logic [31:0] dwd, logic [3:0] ds, logic gi, logic gd,
                              logic mr, logic mw, logic [9:0] ma, logic [31:0] mm);
    vec_t v;
    v.rst = r;  v.ireq = ir; v.iwe = iw; v.iaddr = ia; v.iwdata = iwd; v.istrb = is;
    v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwdata = dwd; v.dstrb = ds;
    v.egi = gi; v.egd = gd; v.ereq = mr; v.ewe = mw; v.eaddr = ma; v.emask = mm;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0:       a = BASE - 32'd4;
      1:       a = BASE + DEPTH * 4 - 4;
      2:       a = BASE + DEPTH * 4;
      3:       a = $urandom();
      default: a = BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(0, 3);
    endcase
    return a;
  endfunction

  vec_t vecs [17];
  logic [31:0] merged;

  initial begin
    lw = 0; pv = 0; pown = 0; perr = 0; pdata = '0; last_gi = 0; last_gd = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    merged = (init_word(2) & 32'hFF00_00FF) | 32'h0022_3300;

    vecs[0]  = mk(0, 1,0,32'h8000_0014,0,0,    0,0,0,0,0,                          1,0,1,0,10'd5,0);
    vecs[1]  = mk(0, 0,0,0,0,0,                1,1,32'h8000_0008,32'h1122_3344,4'b0110, 0,1,1,1,10'd2,32'h00FF_FF00);
    vecs[2]  = mk(0, 0,0,0,0,0,                1,0,32'h8000_0008,0,0,              0,1,1,0,10'd2,0);
    vecs[3]  = mk(0, 0,0,0,0,0,                0,0,0,0,0,                          0,0,0,0,10'd0,0);
    vecs[4]  = mk(0, 1,0,32'h7FFF_FFFC,0,0,    0,0,0,0,0,                          1,0,0,0,10'd0,0);
    vecs[5]  = mk(0, 0,0,0,0,0,                1,0,32'h8000_1000,0,0,              0,1,0,0,10'd0,0);
    vecs[6]  = mk(1, 1,0,32'h8000_0000,0,0,    1,0,32'h8000_0004,0,0,              0,0,0,0,10'd0,0);
    for (int i = 7; i <= 12; i++)
      vecs[i] = mk(0, 1,0,32'h8000_0000,0,0,   1,0,32'h8000_0004,0,0,
                   (i % 2) == 0, (i % 2) == 1, 1, 0, (i % 2) == 1 ? 10'd1 : 10'd0, 0);
    vecs[13] = mk(0, 1,0,32'h8000_0000,0,0,    0,0,0,0,0,                          1,0,1,0,10'd0,0);
    vecs[14] = mk(1, 1,0,32'h8000_0000,0,0,    0,0,0,0,0,                          0,0,0,0,10'd0,0);
    vecs[15] = mk(0, 1,0,32'h8000_0000,0,0,    1,0,32'h8000_0004,0,0,              0,1,1,0,10'd1,0);
    vecs[16] = mk(0, 1,0,32'h8000_0000,0,0,    1,0,32'h8000_0004,0,0,              1,0,1,0,10'd0,0);

    // Reset with both ports requesting
    rst = 1; preload = 1;
    instr_req = 1; instr_we = 0; instr_addr = BASE; instr_wdata = '0; instr_strb = '0;
    data_req  = 1; data_we  = 0; data_addr  = BASE; data_wdata  = '0; data_strb  = '0;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      #4;
      model_step();
      @(posedge clk); #1;
    end
    preload = 0; rst = 0; instr_req = 0; data_req = 0;

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst;
      instr_req = vecs[i].ireq; instr_we = vecs[i].iwe; instr_addr = vecs[i].iaddr;
      instr_wdata = vecs[i].iwdata; instr_strb = vecs[i].istrb;
      data_req = vecs[i].dreq; data_we = vecs[i].dwe; data_addr = vecs[i].daddr;
      data_wdata = vecs[i].dwdata; data_strb = vecs[i].dstrb;
      #4;
      chk($sformatf("vec%0d_instr_gnt", i), 32'(instr_gnt), 32'(vecs[i].egi));
      chk($sformatf("vec%0d_data_gnt", i),  32'(data_gnt),  32'(vecs[i].egd));
      chk($sformatf("vec%0d_mem_req", i),   32'(mem_req),   32'(vecs[i].ereq));
      chk($sformatf("vec%0d_mem_we", i),    32'(mem_we),    32'(vecs[i].ewe));
      chk($sformatf("vec%0d_mem_addr", i),  32'(mem_addr),  32'(vecs[i].eaddr));
      chk($sformatf("vec%0d_mem_wmask", i), mem_wmask,      vecs[i].emask);
      if (i == 1) chk("read_word5", instr_rdata, 32'hDEAD_BEEF);
      if (i == 3) chk("merged_word2", data_rdata, merged);
      if (i == 5 || i == 6) chk($sformatf("vec%0d_oow_err", i), 32'(instr_err), 32'(i == 5));
      if (i == 14) chk("reset_drops_rvalid", 32'(instr_rvalid), 32'd0);
      model_step();
      @(posedge clk); #1;
    end
    rst = 0; instr_req = 0; data_req = 0;

    // Randomized traffic; a requester holds its request until granted
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!(instr_req && !last_gi)) begin
        instr_req = $urandom_range(0, 2) != 0; instr_we = $urandom_range(0, 3) == 0;
        instr_addr = rand_addr(); instr_wdata = $urandom(); instr_strb = 4'($urandom());
      end
      if (!(data_req && !last_gd)) begin
        data_req = $urandom_range(0, 2) != 0; data_we = $urandom_range(0, 1) == 0;
        data_addr = rand_addr(); data_wdata = $urandom(); data_strb = 4'($urandom());
      end
      #4;
      model_step();
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

Two-requester round-robin arbiter that lets the picorv32 instruction and data ports share one single-port `sram_mem` instance, replacing the current pair of independent instruction and data memories in the tiny SoC. It accepts req/gnt requests from both ports, forwards one request per cycle to the SRAM, and translates byte addresses into word indices relative to a base address. It also converts byte strobes into the SRAM's bit mask and routes the one-cycle-latency read data back to the owning port with a valid flag. Out-of-window accesses are absorbed locally and flagged as errors.

## Interface
Parameters:
- `Depth`, `1 << 20`: SRAM depth in 32-bit words; must be a power of two.
- `BaseAddr`, `32'h80000000`: byte address mapped to SRAM word 0.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `instr_req_i`  in  1  instruction-port request.
- `instr_we_i`  in  1  instruction-port write enable.
- `instr_addr_i`  in  32  instruction-port byte address.
- `instr_wdata_i`  in  32  instruction-port write data.
- `instr_strb_i`  in  4  instruction-port byte strobes.
- `instr_gnt_o`  out  1  instruction-port grant.
- `instr_rvalid_o`  out  1  instruction-port response valid.
- `instr_rdata_o`  out  32  instruction-port read data.
- `instr_err_o`  out  1  instruction-port error flag.
- `data_*`: the same set of signals for the data port.
- `mem_req_o`  out  1  SRAM request.
- `mem_we_o`  out  1  SRAM write enable.
- `mem_addr_o`  out  $clog2(Depth)  SRAM word index.
- `mem_wdata_o`  out  32  SRAM write data.
- `mem_wmask_o`  out  32  SRAM bit mask; each strobe bit is replicated ×8.
- `mem_rdata_i`  in  32  SRAM read data, valid one cycle after the request.

## Operation
- Arbitration
  - Combinational, evaluated every cycle.
  - One request only: that port is granted.
  - Both requesting: the port that did not win the last grant is granted.
  - `last_winner` resets to instr, so data wins the first contested cycle.
- A requester holds req, addr, we, wdata and strb stable until gnt. The arbiter never revokes a grant in the same cycle it is asserted.
- Address check on the granted port
  - `off = addr - BaseAddr`, 32-bit wrap-around subtraction.
  - In window when `off < Depth*4`.
  - In window: `mem_req_o=1`, `mem_addr_o=off[2+:$clog2(Depth)]`, and the remaining `mem_*` outputs are copied from the port, with `wmask` expanded from strb.
  - Out of window: grant still given, `mem_req_o=0`, and the response is marked as an error.
  - `addr[1:0]` is ignored.
- Response register, loaded on every grant with {valid, owner, err}
  - Next cycle: the owner's `rvalid_o=1`.
  - `rdata_o` carries `mem_rdata_i`, or 0 when err is set or the access was a write.
  - `err_o` equals the stored err.
- The non-owner's rvalid, err and rdata are 0.
- Writes also produce an rvalid pulse so both ports see a uniform completion.
- No grant in a cycle: the response valid clears next cycle.
- When no grant is given, `mem_req_o=0` and the remaining `mem_*` outputs are 0.

## Timing
- Grant: same cycle as req, zero latency.
- Response: exactly 1 cycle after grant.
- Throughput: one access per cycle total. Under full contention each port gets one grant every 2 cycles.
- Back-to-back grants to the same port are legal. The response register updates every cycle, with no bubble.
- Reset
  - While `rst_i=1`: all gnt, rvalid, err and rdata outputs are 0, and `mem_req_o=0`, even if req is high.
  - On the first cycle after reset, `last_winner=instr` and the response valid is 0.
  - Reset asserted with a response pending: the response is dropped and no rvalid fires.
- Boundary cases
  - `addr == BaseAddr + Depth*4 - 4`: in window.
  - `addr == BaseAddr + Depth*4`: out of window.
  - `addr < BaseAddr`: out of window, because the subtraction wraps to a large value.
- Simultaneous grant and response in the same cycle are independent. A port may receive rvalid for its previous access while being granted a new one.

## Test plan
- Single instr read: SRAM word 5 preloaded with 0xDEADBEEF, `instr_addr=0x80000014` -> `instr_gnt=1` the same cycle, `mem_addr_o=5`; next cycle `instr_rvalid=1`, `instr_rdata=0xDEADBEEF`, `instr_err=0`.
- Contention: both ports request every cycle for 6 cycles after reset -> grant order data, instr, data, instr, data, instr; each rvalid goes to the correct owner one cycle after its grant.
- Data write with `strb=4'b0110`, `wdata=0x11223344`, `addr=0x80000008` -> `mem_wmask_o=0x00FFFF00`, `mem_addr_o=2`, `mem_we_o=1`; next cycle `data_rvalid=1`, `data_rdata=0`. A subsequent read of the same word returns the old bytes 3 and 0 with new bytes 2 and 1.
- Out-of-window access at `addr=0x7FFFFFFC` and at `BaseAddr+Depth*4` -> gnt=1, `mem_req_o=0`; next cycle rvalid=1, err=1, rdata=0.
- Reset mid-operation: grant issued in cycle N, `rst_i=1` in cycle N+1 -> no rvalid in N+1; after release, the first contested cycle grants data.
